// File: rtl/pam4_gray_mapper_tx.sv
// Serialises WORD_W-bit words into WORD_W/2 PAM4 symbols, each optionally Gray-mapped (optional SYM_CNT_EN adds sym_count).
// Latency: first symbol is presented the cycle after the accept edge; sustains 1 symbol/cycle with zero-bubble word reload.
// Backpressure: symbol_ready low freezes the word in flight; word_ready rises only when empty or on the last symbol's handshake.
module pam4_gray_mapper_tx #(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              gray_en,
    output logic [1:0]        symbol_out,
    output logic              symbol_valid,
    input  logic              symbol_ready
`ifdef SYM_CNT_EN
    ,
    output logic [31:0]       sym_count
`endif
);

    localparam int N  = WORD_W / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic              mode_q, mode_nxt;
    logic              last, accept, sym_hs;
    logic [1:0]        raw;

    assign last       = (cnt == LAST);
    assign word_ready = (state == EMPTY) || (last && symbol_ready);
    assign accept     = word_valid && word_ready;
    assign sym_hs     = (state == BUSY) && symbol_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= EMPTY;
            cnt    <= '0;
            shreg  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Accept wins over the last-symbol retire so back-to-back words reload without a bubble.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        mode_nxt  = mode_q;
        if (accept) begin
            state_nxt = BUSY;
            cnt_nxt   = '0;
            shreg_nxt = word_in;
            mode_nxt  = gray_en;
        end else if (sym_hs) begin
            if (last) begin
                state_nxt = EMPTY;
            end else begin
                cnt_nxt   = cnt + CW'(1);
                shreg_nxt = MSB_FIRST ? (shreg << 2) : (shreg >> 2);
            end
        end
    end

    assign raw          = MSB_FIRST ? shreg[WORD_W-1 -: 2] : shreg[1:0];
    assign symbol_valid = (state == BUSY);

    always_comb begin
        symbol_out = 2'b00;
        if (state == BUSY) begin
            symbol_out = mode_q ? {raw[1], raw[1] ^ raw[0]} : raw;
        end
    end

`ifdef SYM_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_count <= 32'd0;
        end else if (sym_hs) begin
            sym_count <= sym_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pam4_gray_mapper_tx.sv
// Directed bench for pam4_gray_mapper_tx: MSB-first, LSB-first and WORD_W=2 instances share clock, reset and data inputs.
module tb_pam4_gray_mapper_tx;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] word_in = 8'h00;
    logic       gray_en = 1'b0;
    logic       symbol_ready = 1'b1;
    logic       wv [3];
    logic       wr [3];
    logic [1:0] so [3];
    logic       sv [3];
`ifdef SYM_CNT_EN
    logic [31:0] cnt0, cnt1, cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pam4_gray_mapper_tx #(.WORD_W(8), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rstn(rstn), .word_in(word_in), .word_valid(wv[0]), .word_ready(wr[0]),
        .gray_en(gray_en), .symbol_out(so[0]), .symbol_valid(sv[0]), .symbol_ready(symbol_ready)
`ifdef SYM_CNT_EN
        , .sym_count(cnt0)
`endif
    );

    pam4_gray_mapper_tx #(.WORD_W(8), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rstn(rstn), .word_in(word_in), .word_valid(wv[1]), .word_ready(wr[1]),
        .gray_en(gray_en), .symbol_out(so[1]), .symbol_valid(sv[1]), .symbol_ready(symbol_ready)
`ifdef SYM_CNT_EN
        , .sym_count(cnt1)
`endif
    );

    pam4_gray_mapper_tx #(.WORD_W(2), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rstn(rstn), .word_in(word_in[1:0]), .word_valid(wv[2]), .word_ready(wr[2]),
        .gray_en(gray_en), .symbol_out(so[2]), .symbol_valid(sv[2]), .symbol_ready(symbol_ready)
`ifdef SYM_CNT_EN
        , .sym_count(cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // exp packs the expected symbols in emission order, first symbol in the top pair of the low 2*nsym bits.
    task automatic run_word(input int d, input logic [7:0] w, input logic g,
                            input logic [7:0] exp, input int nsym);
        @(negedge clk);
        chk("idle_ready", 32'(wr[d]), 32'd1);
        word_in = w;
        gray_en = g;
        wv[d]   = 1'b1;
        @(negedge clk);
        wv[d]   = 1'b0;
        gray_en = ~g;
        for (int i = 0; i < nsym; i++) begin
            if (i > 0) @(negedge clk);
            chk("sym_valid", 32'(sv[d]), 32'd1);
            chk("sym", 32'(so[d]), 32'((exp >> (2 * (nsym - 1 - i))) & 8'h03));
        end
        @(negedge clk);
        chk("done_valid", 32'(sv[d]), 32'd0);
        chk("done_sym", 32'(so[d]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] seq;
        for (int i = 0; i < 3; i++) wv[i] = 1'b0;

        // Reset state while rstn is held low
        #2;
        chk("rst_valid", 32'(sv[0]), 32'd0);
        chk("rst_sym", 32'(so[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(wr[0]), 32'd1);

        // Gray, MSB first: B4 -> 11,10,01,00
        run_word(0, 8'hB4, 1'b1, 8'hE4, 4);
        // LSB first, binary then Gray
        run_word(1, 8'hB4, 1'b0, 8'h1E, 4);
        run_word(1, 8'hB4, 1'b1, 8'h1B, 4);

        // Back-to-back 1B then E4 with word_valid held high
        seq = 16'h1BE4;
        gray_en = 1'b0;
        @(negedge clk);
        word_in = 8'h1B;
        wv[0]   = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 8) chk("b2b_ready", 32'(wr[0]), 32'((k == 0) || (k == 4)));
            if (k >= 1) begin
                chk("b2b_valid", 32'(sv[0]), 32'd1);
                chk("b2b_sym", 32'(so[0]), 32'((seq >> (2 * (8 - k))) & 16'h0003));
            end
            if (k == 1) word_in = 8'hE4;
            if (k == 5) wv[0] = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_valid", 32'(sv[0]), 32'd0);

        // Backpressure: B4 binary, stall after the first symbol
        @(negedge clk);
        word_in = 8'hB4;
        gray_en = 1'b0;
        wv[0]   = 1'b1;
        @(negedge clk);
        wv[0] = 1'b0;
        chk("bp_sym0", 32'(so[0]), 32'h2);
        symbol_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_sym", 32'(so[0]), 32'h2);
            chk("bp_hold_valid", 32'(sv[0]), 32'd1);
            chk("bp_hold_ready", 32'(wr[0]), 32'd0);
        end
        symbol_ready = 1'b1;
        @(negedge clk);
        chk("bp_sym1", 32'(so[0]), 32'h3);
        @(negedge clk);
        chk("bp_sym2", 32'(so[0]), 32'h1);
        @(negedge clk);
        chk("bp_sym3", 32'(so[0]), 32'h0);
        @(negedge clk);
        chk("bp_end_valid", 32'(sv[0]), 32'd0);

        // Asynchronous reset mid-word
        @(negedge clk);
        word_in = 8'hB4;
        wv[0]   = 1'b1;
        @(negedge clk);
        wv[0] = 1'b0;
        chk("mid_sym0", 32'(so[0]), 32'h2);
        @(negedge clk);
        chk("mid_sym1", 32'(so[0]), 32'h3);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_valid", 32'(sv[0]), 32'd0);
        chk("async_sym", 32'(so[0]), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(wr[0]), 32'd1);
        chk("post_rst_valid", 32'(sv[0]), 32'd0);
        run_word(0, 8'h00, 1'b0, 8'h00, 4);

        // WORD_W=2: full rate, ready stays high while symbols flow
        @(negedge clk);
        word_in = 8'h02;
        gray_en = 1'b1;
        wv[2]   = 1'b1;
        chk("w2_ready0", 32'(wr[2]), 32'd1);
        @(negedge clk);
        chk("w2_sym0", 32'(so[2]), 32'h3);
        chk("w2_valid0", 32'(sv[2]), 32'd1);
        chk("w2_ready1", 32'(wr[2]), 32'd1);
        word_in = 8'h03;
        gray_en = 1'b0;
        @(negedge clk);
        chk("w2_sym1", 32'(so[2]), 32'h3);
        chk("w2_valid1", 32'(sv[2]), 32'd1);
        wv[2] = 1'b0;
        @(negedge clk);
        chk("w2_end_valid", 32'(sv[2]), 32'd0);

`ifdef SYM_CNT_EN
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("cnt_rst", cnt0, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_word(0, 8'h1B, 1'b0, 8'h1B, 4);
        run_word(0, 8'hE4, 1'b0, 8'hE4, 4);
        run_word(0, 8'hB4, 1'b1, 8'hE4, 4);
        chk("cnt_12", cnt0, 32'd12);
        force dut0.sym_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut0.sym_count;
        run_word(0, 8'h00, 1'b0, 8'h00, 4);
        chk("cnt_wrap", cnt0, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pam4_gray_mapper_tx.md
Name: pam4_gray_mapper_tx

Overview:
Transmit-side word-to-symbol stage that sits directly upstream of the TX precoder. It accepts WORD_W-bit data words over a valid/ready handshake and serialises each word into WORD_W/2 two-bit PAM4 symbols, one per cycle. Each symbol is optionally Gray-mapped. The symbol output with its valid strobe drives the precoder's symbol input and enable directly.

Parameters:
WORD_W, 8, input word width in bits; must be even and >= 2; N = WORD_W/2 symbols per word
MSB_FIRST, 1, 1 = emit the symbol from bits [WORD_W-1:WORD_W-2] first; 0 = emit the symbol from bits [1:0] first

Ports:
clk  input  1  system clock; all state updates on the rising edge
rstn  input  1  asynchronous active-low reset
word_in  input  WORD_W  data word to serialise
word_valid  input  1  word_in is valid
word_ready  output  1  block accepts word_in this cycle
gray_en  input  1  1 = Gray-map the symbols of the word being accepted; 0 = pass binary
symbol_out  output  2  current PAM4 symbol, to the precoder symbol input
symbol_valid  output  1  symbol_out is valid, to the precoder enable
symbol_ready  input  1  downstream takes the symbol; tie to 1 for the precoder (it has no backpressure)

Behaviour:
- Reset (rstn low, asynchronous):
  - loaded=0, cnt=0, shreg=0, mode_q=0.
  - symbol_valid=0 and symbol_out=2'b00 immediately.
  - word_ready=1 once rstn is high.
  - Reset mid-word discards all remaining symbols; nothing partial is emitted after reset.
- States:
  - EMPTY: loaded=0.
  - BUSY: loaded=1, cnt = index (0..N-1) of the symbol currently presented.
- Accept (handshake): a word is accepted when word_valid && word_ready at a clock edge.
  - On accept: shreg <= word_in, mode_q <= gray_en, cnt <= 0, loaded <= 1.
  - gray_en is sampled only at accept; changing it mid-word has no effect on that word.
- word_ready = !loaded || (cnt==N-1 && symbol_ready).
  - This is a combinational path from symbol_ready only; it does not depend on word_valid.
- Output:
  - symbol_valid = loaded.
  - symbol_out = map(raw), where raw = shreg[WORD_W-1:WORD_W-2] if MSB_FIRST, else shreg[1:0].
  - Both outputs are driven from registers only. symbol_out is 2'b00 when loaded=0.
- Gray map (mode_q=1): 00->00, 01->01, 10->11, 11->10. With mode_q=0, raw passes through unchanged.
- Symbol handshake: symbol_valid && symbol_ready at a clock edge.
  - If cnt<N-1: shift shreg by 2 toward the emitted end and increment cnt.
  - If cnt==N-1 and a new word is accepted on the same edge: load the new word; zero-bubble back-to-back.
  - If cnt==N-1 and no new word: loaded <= 0, return to EMPTY.
- symbol_ready low while BUSY: shreg, cnt, symbol_out and symbol_valid hold stable. No new word is accepted.
- Latency: first symbol of an accepted word appears on the cycle after the accept edge.
  - Sustained throughput is 1 symbol/cycle when symbol_ready=1 and word_valid is held high.
- WORD_W=2 (N=1): each word yields one symbol. word_ready is 1 whenever symbol_ready=1, giving full rate.
- word_valid with word_ready=0: word is not taken, no state change. The upstream source must hold word_in.

Optional Feature:
Macro SYM_CNT_EN.
- Defined: adds output port sym_count [31:0].
  - Increments by 1 on every symbol handshake; wraps 0xFFFFFFFF -> 0.
  - Reset to 0 asynchronously with rstn; not cleared between words.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Basic Gray, MSB first: reset, then word_in=8'hB4, gray_en=1, symbol_ready=1. Required: symbols 11,10,01,00 with symbol_valid=1 on the 4 cycles after accept, then symbol_valid=0.
2. Binary, LSB first: MSB_FIRST=0, word_in=8'hB4, gray_en=0. Required: symbols 00,01,11,10. Repeat with gray_en=1: required 00,01,10,11.
3. Back-to-back: words 8'h1B then 8'hE4, word_valid held high, gray_en=0. Required: 8 consecutive valid symbols 00,01,10,11,11,10,01,00 with no bubble, and word_ready=1 only on the accept cycle of each word (cycles 0 and 4).
4. Backpressure: word 8'hB4, gray_en=0, symbol_ready=0 for 3 cycles after the first symbol. Required: symbol_out stays at 10 with symbol_valid=1 throughout; sequence resumes 11,01,00 when symbol_ready returns; word_ready=0 throughout the stall.
5. Reset mid-word: assert rstn low after the 2nd symbol of 8'hB4. Required: symbol_valid=0 and symbol_out=00 immediately (asynchronous); word_ready=1 after release; next word 8'h00 gives 00,00,00,00.
6. SYM_CNT_EN defined: 3 words streamed (12 symbols). Required: sym_count=12; preload 0xFFFFFFFE via force, send 1 word, required sym_count=2 (wrap).
